// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared-bus arbiter with grant watchdog
module bus_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] request,
    input  logic                   bus_begin_transaction,
    input  logic                   bus_end_transaction,
    input  logic                   bus_error,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [1:0]             owner_id,
    output logic                   bus_idle,
    output logic                   timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(GRANT_TIMEOUT - 1);

    state_t                 state, state_next;
    logic [NUM_MASTERS-1:0] grant_next;
    logic [1:0]             owner_next;
    logic [1:0]             last, last_next;
    logic [7:0]             count, count_next;
    logic                   pulse_next;

    logic [3:0]             req_ext;
    logic                   found;
    logic [1:0]             winner;
    logic [NUM_MASTERS-1:0] winner_onehot;

    assign req_ext  = 4'(request);
    assign bus_idle = (state == IDLE);

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        logic [1:0] cand;
        found         = 1'b0;
        winner        = 2'd0;
        winner_onehot = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = 2'((int'(last) + i) % NUM_MASTERS);
            if (!found && req_ext[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            winner_onehot[i] = (winner == 2'(i));
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        owner_next = owner_id;
        last_next  = last;
        count_next = count;
        pulse_next = 1'b0;
        unique case (state)
            IDLE: begin
                grant_next = '0;
                if (found) begin
                    state_next = GRANTED;
                    grant_next = winner_onehot;
                    owner_next = winner;
                    last_next  = winner;
                    count_next = 8'd0;
                end
            end
            GRANTED: begin
                if (bus_error) begin
                    state_next = RELEASE;
                    grant_next = '0;
                end else if (bus_begin_transaction) begin
                    if (bus_end_transaction) begin
                        state_next = RELEASE;
                        grant_next = '0;
                    end else begin
                        state_next = BUSY;
                    end
                end else if (!req_ext[owner_id]) begin
                    state_next = RELEASE;
                    grant_next = '0;
                end else if (count == TIMEOUT_LAST) begin
                    state_next = RELEASE;
                    grant_next = '0;
                    pulse_next = 1'b1;
                end else begin
                    count_next = count + 8'd1;
                end
            end
            BUSY: begin
                if (bus_end_transaction || bus_error) begin
                    state_next = RELEASE;
                    grant_next = '0;
                end
            end
            RELEASE: begin
                state_next = IDLE;
                grant_next = '0;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= '0;
            owner_id      <= 2'd0;
            last          <= 2'd3;
            count         <= 8'd0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            owner_id      <= owner_next;
            last          <= last_next;
            count         <= count_next;
            timeout_pulse <= pulse_next;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic       bus_begin_transaction;
    logic       bus_end_transaction;
    logic       bus_error;
    logic [3:0] grant;
    logic [1:0] owner_id;
    logic       bus_idle;
    logic       timeout_pulse;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] owner;
    } exp_t;

    exp_t expected[$];

    bus_arbiter #(.NUM_MASTERS(4), .GRANT_TIMEOUT(16)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .request               (request),
        .bus_begin_transaction (bus_begin_transaction),
        .bus_end_transaction   (bus_end_transaction),
        .bus_error             (bus_error),
        .grant                 (grant),
        .owner_id              (owner_id),
        .bus_idle              (bus_idle),
        .timeout_pulse         (timeout_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] o);
        exp_t e;
        e.grant = g;
        e.owner = o;
        expected.push_back(e);
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (grant == 4'b0 && n < 8) begin
            step(1);
            n++;
        end
        check(name, 32'(grant != 4'b0), 32'd1);
    endtask

    // Monitor: every fresh grant is matched against the oldest expected one.
    logic [3:0] prev_grant = 4'b0;
    always @(negedge clock) begin
        if (!reset) begin
            check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            if (grant != 4'b0 && prev_grant == 4'b0) begin
                if (expected.size() == 0) begin
                    check("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    exp_t e;
                    e = expected.pop_front();
                    check("sb_grant", 32'(grant), 32'(e.grant));
                    check("sb_owner", 32'(owner_id), 32'(e.owner));
                end
            end
        end
        prev_grant = grant;
    end

    initial begin
        reset = 1'b1;
        request = 4'b0;
        bus_begin_transaction = 1'b0;
        bus_end_transaction = 1'b0;
        bus_error = 1'b0;
        step(2);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_owner", 32'(owner_id), 32'd0);
        check("rst_idle", 32'(bus_idle), 32'd1);
        check("rst_pulse", 32'(timeout_pulse), 32'd0);
        reset = 1'b0;

        // Single request: one-cycle latency, grant drops after end.
        step(3);
        request = 4'b0001;
        push(4'b0001, 2'd0);
        step(1);
        check("latency_grant", 32'(grant), 32'h1);
        step(1);
        bus_begin_transaction = 1'b1;
        step(1);
        bus_begin_transaction = 1'b0;
        check("busy_grant", 32'(grant), 32'h1);
        step(3);
        bus_end_transaction = 1'b1;
        request = 4'b0;
        step(1);
        bus_end_transaction = 1'b0;
        check("end_grant", 32'(grant), 32'd0);
        check("release_idle", 32'(bus_idle), 32'd0);
        step(1);
        check("idle_after", 32'(bus_idle), 32'd1);

        // Fairness after a fresh reset: 0,1,2,3,0.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push(4'(1 << (k % 4)), 2'(k % 4));
            wait_grant("fair_wait");
            bus_begin_transaction = 1'b1;
            step(1);
            bus_begin_transaction = 1'b0;
            step(2);
            bus_end_transaction = 1'b1;
            step(1);
            bus_end_transaction = 1'b0;
        end
        request = 4'b0;
        step(2);

        // Watchdog: last=0, master 2 alone, never begins.
        request = 4'b0100;
        push(4'b0100, 2'd2);
        step(1);
        check("to_grant", 32'(grant), 32'h4);
        step(15);
        check("to_hold", 32'(grant), 32'h4);
        check("to_no_pulse", 32'(timeout_pulse), 32'd0);
        step(1);
        check("to_pulse", 32'(timeout_pulse), 32'd1);
        check("to_drop", 32'(grant), 32'd0);
        request = 4'b0110;
        push(4'b0010, 2'd1);
        step(1);
        check("to_pulse_once", 32'(timeout_pulse), 32'd0);
        check("to_idle", 32'(bus_idle), 32'd1);
        step(1);
        check("to_next_other", 32'(grant), 32'h2);

        // Withdrawal: master 1 drops its request, master 3 waiting.
        request = 4'b1010;
        step(2);
        request = 4'b1000;
        push(4'b1000, 2'd3);
        step(1);
        check("wd_drop", 32'(grant), 32'd0);
        check("wd_no_pulse", 32'(timeout_pulse), 32'd0);
        step(2);
        check("wd_next", 32'(grant), 32'h8);

        // Zero-length transaction: begin and end together.
        bus_begin_transaction = 1'b1;
        bus_end_transaction = 1'b1;
        request = 4'b0;
        step(1);
        bus_begin_transaction = 1'b0;
        bus_end_transaction = 1'b0;
        check("zero_len_drop", 32'(grant), 32'd0);
        check("zero_len_release", 32'(bus_idle), 32'd0);
        step(1);

        // Error while BUSY: last=3, so master 0 wins.
        request = 4'b0001;
        push(4'b0001, 2'd0);
        wait_grant("err_wait");
        bus_begin_transaction = 1'b1;
        step(1);
        bus_begin_transaction = 1'b0;
        step(1);
        bus_error = 1'b1;
        request = 4'b0;
        step(1);
        bus_error = 1'b0;
        check("err_drop", 32'(grant), 32'd0);
        step(1);

        // Reset while BUSY, then master 0 priority restored.
        request = 4'b0010;
        push(4'b0010, 2'd1);
        wait_grant("rb_wait");
        bus_begin_transaction = 1'b1;
        step(1);
        bus_begin_transaction = 1'b0;
        check("rb_busy", 32'(grant), 32'h2);
        reset = 1'b1;
        step(1);
        check("rb_grant", 32'(grant), 32'd0);
        check("rb_owner", 32'(owner_id), 32'd0);
        check("rb_idle", 32'(bus_idle), 32'd1);
        reset = 1'b0;
        request = 4'b1010;
        push(4'b0010, 2'd1);
        step(1);
        check("rb_first", 32'(grant), 32'h2);
        request = 4'b0;
        step(3);

        check("sb_drained", 32'(expected.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
